// File: rtl/mdu_pkg.sv
// Shared MDU definitions: E-stage opcode encoding (also used by the result mux and
// hazard unit) and the sequencer state encoding.
package mdu_pkg;

  localparam logic [3:0] OpNone  = 4'b0000;
  localparam logic [3:0] OpMult  = 4'b0001;
  localparam logic [3:0] OpMultu = 4'b0010;
  localparam logic [3:0] OpDiv   = 4'b0011;
  localparam logic [3:0] OpDivu  = 4'b0100;
  localparam logic [3:0] OpMfhi  = 4'b0101;
  localparam logic [3:0] OpMflo  = 4'b0110;
  localparam logic [3:0] OpMthi  = 4'b0111;
  localparam logic [3:0] OpMtlo  = 4'b1000;

  typedef enum logic [1:0] {
    StIdle,
    StMult,
    StDiv
  } mdu_state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational 32x32 multiply (64-bit product) and divide/remainder, signed or unsigned.
module mdu_arith (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_signed,
  output logic [63:0] prod,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  // Low 64 bits of the extended product are exact for both signednesses.
  assign a_ext = is_signed ? {{32{a[31]}}, a} : {32'b0, a};
  assign b_ext = is_signed ? {{32{b[31]}}, b} : {32'b0, b};
  assign prod  = a_ext * b_ext;

  assign a_neg = is_signed & a[31];
  assign b_neg = is_signed & b[31];
  assign a_mag = a_neg ? (~a + 32'd1) : a;
  assign b_mag = b_neg ? (~b + 32'd1) : b;

  // Divide magnitudes, then restore signs: quotient truncates toward zero and the
  // remainder follows the dividend. Zero divisor yields zeros; the result is never committed.
  always_comb begin
    q_mag = '0;
    r_mag = '0;
    if (b_mag != 32'd0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
  end

  assign quot = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem  = a_neg ? (~r_mag + 32'd1) : r_mag;

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MDU sequencer: owns HI/LO, computes the result at Start, holds it
// pending for the busy period and commits it on the final busy edge.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDU_Ctr,
  input  logic        E_Valid,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_MDU_Use,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        MDU_Stall
);

  localparam logic [3:0] MultLoad = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES - 1);

  mdu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_dz_q, pend_dz_d;

  logic        is_mul;
  logic        is_div;
  logic        is_signed;
  logic [63:0] prod;
  logic [31:0] quot;
  logic [31:0] rem;

  assign is_mul    = (E_MDU_Ctr == OpMult) || (E_MDU_Ctr == OpMultu);
  assign is_div    = (E_MDU_Ctr == OpDiv) || (E_MDU_Ctr == OpDivu);
  assign is_signed = (E_MDU_Ctr == OpMult) || (E_MDU_Ctr == OpDiv);

  mdu_arith u_arith (
    .a         (E_A),
    .b         (E_B),
    .is_signed (is_signed),
    .prod      (prod),
    .quot      (quot),
    .rem       (rem)
  );

  assign Start     = E_Valid && (is_mul || is_div) && (state_q == StIdle);
  assign Busy      = (state_q != StIdle);
  assign MDU_Stall = D_MDU_Use && (Start || Busy);
  assign HI        = hi_q;
  assign LO        = lo_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;
    case (state_q)
      StIdle: begin
        if (Start && is_mul) begin
          pend_hi_d = prod[63:32];
          pend_lo_d = prod[31:0];
          pend_dz_d = 1'b0;
          cnt_d     = MultLoad;
          state_d   = StMult;
        end else if (Start) begin
          pend_hi_d = rem;
          pend_lo_d = quot;
          pend_dz_d = (E_B == 32'd0);
          cnt_d     = DivLoad;
          state_d   = StDiv;
        end else if (E_Valid && (E_MDU_Ctr == OpMthi)) begin
          hi_d = E_A;
        end else if (E_Valid && (E_MDU_Ctr == OpMtlo)) begin
          lo_d = E_A;
        end
      end
      StMult, StDiv: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!pend_dz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_dz_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
    end
  end

endmodule
